// File: rtl/rf_param_if.sv
// Bus bundle between the decoder/ALU side (master) and the register file (slave).
// Carries the write port, both read ports, the I/O register and the clear engine handshake.
interface rf_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              st_ce;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] io_in;
  logic [DATA_W-1:0] io_out;
  logic              io_stb;
  logic              clr_req;
  logic              busy;
  logic              st_drop;

  modport master (
    output st_ce, st_addr, st_data, rd_addr_a, rd_addr_b, io_in, clr_req,
    input  rd_data_a, rd_data_b, io_out, io_stb, busy, st_drop
  );

  modport slave (
    input  st_ce, st_addr, st_data, rd_addr_a, rd_addr_b, io_in, clr_req,
    output rd_data_a, rd_data_b, io_out, io_stb, busy, st_drop
  );
endinterface

// File: rtl/rf_param.sv
// Accumulator register file: one write port, two combinational read ports, optional
// memory-mapped I/O register, optional write-through bypass, and a one-entry-per-cycle clear engine.
//
//  state | meaning
//  IDLE  | normal operation, writes and reads served from the array
//  CLEAR | zeroing mem[clr_ptr], one entry per cycle; busy high, writes dropped
module rf_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int IO_EN   = 1,
  parameter int IO_ADDR = 3,
  parameter int BYPASS  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  rf_param_if.slave   bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IO_A  = ADDR_W'(IO_ADDR);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              io_stb_q, io_stb_d;
  logic              st_drop_q, st_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy_w;
  logic              drop_w;
  logic              wr_w;
  logic              io_hit_st;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign busy_w    = (state_q == CLEAR);
  // A clear request in IDLE wins over a simultaneous store.
  assign drop_w    = bus.st_ce && (busy_w || bus.clr_req);
  assign wr_w      = bus.st_ce && !drop_w;
  assign io_hit_st = (IO_EN != 0) && (bus.st_addr == IO_A);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    io_out_d  = io_out_q;
    io_stb_d  = 1'b0;
    st_drop_d = drop_w;
    mem_we    = 1'b0;
    mem_waddr = bus.st_addr;
    mem_wdata = bus.st_data;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else if (wr_w) begin
          if (io_hit_st) begin
            io_out_d = bus.st_data;
            io_stb_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Array is not reset directly; the clear engine zeroes it after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      io_out_q  <= '0;
      io_stb_q  <= 1'b0;
      st_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      io_out_q  <= io_out_d;
      io_stb_q  <= io_stb_d;
      st_drop_q <= st_drop_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [DATA_W-1:0] rd_a_w, rd_b_w;

  always_comb begin
    rd_a_w = mem_q[bus.rd_addr_a];
    if ((IO_EN != 0) && (bus.rd_addr_a == IO_A))                 rd_a_w = bus.io_in;
    else if (busy_w)                                             rd_a_w = '0;
    else if ((BYPASS != 0) && wr_w && (bus.st_addr == bus.rd_addr_a)) rd_a_w = bus.st_data;
  end

  always_comb begin
    rd_b_w = mem_q[bus.rd_addr_b];
    if ((IO_EN != 0) && (bus.rd_addr_b == IO_A))                 rd_b_w = bus.io_in;
    else if (busy_w)                                             rd_b_w = '0;
    else if ((BYPASS != 0) && wr_w && (bus.st_addr == bus.rd_addr_b)) rd_b_w = bus.st_data;
  end

  assign bus.rd_data_a = rd_a_w;
  assign bus.rd_data_b = rd_b_w;
  assign bus.io_out    = io_out_q;
  assign bus.io_stb    = io_stb_q;
  assign bus.busy      = busy_w;
  assign bus.st_drop   = st_drop_q;
endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: stimulus pushes expected values into a scoreboard queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rf_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_param_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  rf_param_if #(.DATA_W(8), .ADDR_W(2)) bus_nb ();

  rf_param #(.DATA_W(8), .ADDR_W(2), .IO_EN(1), .IO_ADDR(3), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave));
  rf_param #(.DATA_W(8), .ADDR_W(2), .IO_EN(1), .IO_ADDR(3), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .bus(bus_nb.slave));

  localparam int S_RDA = 0, S_RDB = 1, S_IOO = 2, S_STB = 3, S_BSY = 4, S_DRP = 5, S_NBA = 6;

  typedef struct {
    int         sel;
    logic [7:0] v;
    string      nm;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stb_seen = 0;

  task automatic exp_v(input int sel, input logic [7:0] v, input string nm);
    chk_t e;
    e.sel = sel; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drive(input logic ce, input logic [1:0] sa, input logic [7:0] sd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic clr);
    bus.st_ce = ce;     bus_nb.st_ce = ce;
    bus.st_addr = sa;   bus_nb.st_addr = sa;
    bus.st_data = sd;   bus_nb.st_data = sd;
    bus.rd_addr_a = ra; bus_nb.rd_addr_a = ra;
    bus.rd_addr_b = rb; bus_nb.rd_addr_b = rb;
    bus.clr_req = clr;  bus_nb.clr_req = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains all expectations queued for this cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.io_stb === 1'b1) stb_seen++;
      while (q.size() > 0) begin
        chk_t e;
        logic [7:0] act;
        e = q.pop_front();
        case (e.sel)
          S_RDA:   act = bus.rd_data_a;
          S_RDB:   act = bus.rd_data_b;
          S_IOO:   act = bus.io_out;
          S_STB:   act = {7'd0, bus.io_stb};
          S_BSY:   act = {7'd0, bus.busy};
          S_DRP:   act = {7'd0, bus.st_drop};
          default: act = bus_nb.rd_data_a;
        endcase
        n_cmp++;
        if (act !== e.v) begin
          n_err++;
          $display("FAIL %s: got %h expected %h at %0t", e.nm, act, e.v, $time);
        end
      end
    end
  end

  initial begin
    bus.io_in = 8'h77; bus_nb.io_in = 8'h77;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // 1: reset clear runs exactly DEPTH cycles
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 2'(i % 3), 2'(i % 3), 0);
      exp_v(S_BSY, 8'd1, "rst_busy");
      exp_v(S_RDA, 8'h00, "rst_rd_busy");
      if (i == 0) exp_v(S_IOO, 8'h00, "rst_io_out");
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0);
    exp_v(S_BSY, 8'd0, "rst_busy_end");
    exp_v(S_RDA, 8'h00, "rst_rd0");
    exp_v(S_RDB, 8'h00, "rst_rd1");
    cyc();
    drive(0, 0, 0, 2, 2, 0);
    exp_v(S_RDA, 8'h00, "rst_rd2");
    exp_v(S_IOO, 8'h00, "rst_io_out2");
    exp_v(S_STB, 8'd0, "rst_stb");
    cyc();

    // 2: bypass vs. non-bypass instance
    drive(1, 1, 8'hA5, 1, 1, 0);
    exp_v(S_RDA, 8'hA5, "byp_same_cycle");
    exp_v(S_NBA, 8'h00, "nobyp_same_cycle");
    cyc();
    drive(0, 0, 0, 1, 1, 0);
    exp_v(S_RDA, 8'hA5, "byp_after");
    exp_v(S_NBA, 8'hA5, "nobyp_after");
    exp_v(S_DRP, 8'd0, "no_drop");
    cyc();

    // 3: I/O register
    drive(1, 3, 8'h3C, 3, 1, 0);
    exp_v(S_RDA, 8'h77, "io_rd_during_wr");
    cyc();
    drive(0, 0, 0, 3, 3, 0);
    exp_v(S_IOO, 8'h3C, "io_out");
    exp_v(S_STB, 8'd1, "io_stb_pulse");
    exp_v(S_RDB, 8'h77, "io_rd_b");
    cyc();
    drive(0, 0, 0, 1, 3, 0);
    exp_v(S_STB, 8'd0, "io_stb_low");
    exp_v(S_IOO, 8'h3C, "io_out_hold");
    exp_v(S_RDA, 8'hA5, "mem1_kept");
    cyc();

    // 4: fill then clear, store during busy is dropped
    drive(1, 0, 8'h11, 0, 0, 0); cyc();
    drive(1, 1, 8'h22, 0, 0, 0); cyc();
    drive(1, 2, 8'h33, 0, 1, 0);
    exp_v(S_RDA, 8'h11, "fill0");
    exp_v(S_RDB, 8'h22, "fill1");
    cyc();
    drive(0, 0, 0, 2, 2, 1);
    exp_v(S_RDA, 8'h33, "fill2");
    exp_v(S_BSY, 8'd0, "clr_req_idle");
    cyc();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) drive(1, 0, 8'h99, 0, 1, 0);
      else        drive(0, 0, 0, 0, 1, 0);
      exp_v(S_BSY, 8'd1, "clr_busy");
      if (k == 1) exp_v(S_RDA, 8'h00, "clr_rd_busy");
      if (k == 2) exp_v(S_DRP, 8'd1, "busy_drop");
      if (k == 3) exp_v(S_DRP, 8'd0, "busy_drop_end");
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0);
    exp_v(S_BSY, 8'd0, "clr_done");
    exp_v(S_RDA, 8'h00, "clr_rd0");
    exp_v(S_RDB, 8'h00, "clr_rd1");
    cyc();
    drive(0, 0, 0, 2, 0, 0);
    exp_v(S_RDA, 8'h00, "clr_rd2");
    cyc();

    // 5: store and clear in the same IDLE cycle
    drive(1, 2, 8'h5A, 2, 2, 1);
    exp_v(S_RDA, 8'h00, "drop_no_bypass");
    cyc();
    drive(0, 0, 0, 2, 2, 0);
    exp_v(S_DRP, 8'd1, "clr_st_drop");
    exp_v(S_BSY, 8'd1, "clr_st_busy");
    cyc();
    for (int k = 0; k < 3; k++) cyc();
    drive(0, 0, 0, 2, 2, 0);
    exp_v(S_BSY, 8'd0, "clr_st_done");
    exp_v(S_RDA, 8'h00, "clr_st_target");
    exp_v(S_DRP, 8'd0, "clr_st_drop_end");
    cyc();

    // 6: reset in the second CLEAR cycle restarts the full clear
    drive(0, 0, 0, 1, 1, 1);
    cyc();
    drive(0, 0, 0, 1, 1, 0);
    cyc();
    rst = 1'b1;
    exp_v(S_BSY, 8'd1, "rst_mid_busy");
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_v(S_BSY, 8'd1, "rst_mid_hold");
      cyc();
    end
    exp_v(S_BSY, 8'd0, "rst_mid_done");
    exp_v(S_IOO, 8'h00, "rst_mid_io_out");
    drive(1, 1, 8'hC3, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 1, 1, 0);
    exp_v(S_RDA, 8'hC3, "same_addr_a");
    exp_v(S_RDB, 8'hC3, "same_addr_b");
    cyc();

    @(negedge clk);
    #1;
    n_cmp++;
    if (stb_seen != 1) begin
      n_err++;
      $display("FAIL io_stb_count: got %0d expected %0d", stb_seen, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
